// File: rtl/hdmi_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_pkg
// Shared definitions for the TMDS channel encoders:
//   - tmds_mode_e   : 3-bit symbol type selected per pixel clock
//   - CTRL_CODE_xx  : the four control-period symbols, indexed by {c1,c0}
//   - GUARD_CODE_A/B: the two guard-band symbols
//   - TERC4_TABLE   : 16-entry TERC4 table, entry n is the symbol for nibble n
//   - decode_mode   : folds the unused mode encodings 5..7 onto CONTROL
//   - control_code  : {c1,c0} to control symbol
// All symbols are written tmds[9:0]; bit 0 goes out on the wire first.
// -----------------------------------------------------------------------------
package hdmi_pkg;

    typedef enum logic [2:0] {
        MODE_CONTROL     = 3'd0,
        MODE_VIDEO       = 3'd1,
        MODE_DATA_ISLAND = 3'd2,
        MODE_VIDEO_GUARD = 3'd3,
        MODE_DATA_GUARD  = 3'd4
    } tmds_mode_e;

    localparam logic [9:0] CTRL_CODE_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_CODE_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_CODE_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_CODE_11 = 10'b1010101011;

    // GUARD_CODE_A: video guard on channels 0 and 2.
    // GUARD_CODE_B: video guard on channel 1, data guard on channels 1 and 2.
    localparam logic [9:0] GUARD_CODE_A = 10'b1011001100;
    localparam logic [9:0] GUARD_CODE_B = 10'b0100110011;

    // Packed so that TERC4_TABLE[n] is the code for nibble n (entry 15 first).
    localparam logic [15:0][9:0] TERC4_TABLE = {
        10'b1011000011,  // 1111
        10'b0101100011,  // 1110
        10'b1001110001,  // 1101
        10'b1010001110,  // 1100
        10'b1011000110,  // 1011
        10'b0110011100,  // 1010
        10'b0100111001,  // 1001
        10'b1011001100,  // 1000
        10'b0100111100,  // 0111
        10'b0110001110,  // 0110
        10'b0100011110,  // 0101
        10'b0101110001,  // 0100
        10'b1011100010,  // 0011
        10'b1011100100,  // 0010
        10'b1001100011,  // 0001
        10'b1010011100   // 0000
    };

    function automatic tmds_mode_e decode_mode(input logic [2:0] raw);
        tmds_mode_e m;
        case (raw)
            3'd1:    m = MODE_VIDEO;
            3'd2:    m = MODE_DATA_ISLAND;
            3'd3:    m = MODE_VIDEO_GUARD;
            3'd4:    m = MODE_DATA_GUARD;
            default: m = MODE_CONTROL;
        endcase
        return m;
    endfunction

    function automatic logic [9:0] control_code(input logic [1:0] c);
        logic [9:0] sym;
        case (c)
            2'b00:   sym = CTRL_CODE_00;
            2'b01:   sym = CTRL_CODE_01;
            2'b10:   sym = CTRL_CODE_10;
            default: sym = CTRL_CODE_11;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/tmds_encoder_3ch.sv
// -----------------------------------------------------------------------------
// tmds_encoder_3ch
// Three channel encoders (CN = 0, 1, 2) sharing one symbol type, feeding the
// three symbol inputs of the 10:1 serializer.
// Ports:
//   clk_pixel     in        1  pixel clock
//   reset         in        1  synchronous, active-high
//   mode          in        3  symbol type, common to all channels
//   video_data    in   [3][8]  pixel components, index = channel
//   control_data  in   [3][2]  {c1,c0} per channel
//   aux_data      in   [3][4]  TERC4 nibbles per channel
//   tmds          out [3][10]  registered symbols per channel
// -----------------------------------------------------------------------------
module tmds_encoder_3ch (
    input  logic            clk_pixel,
    input  logic            reset,
    input  logic [2:0]      mode,
    input  logic [2:0][7:0] video_data,
    input  logic [2:0][1:0] control_data,
    input  logic [2:0][3:0] aux_data,
    output logic [2:0][9:0] tmds
);

    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        tmds_channel_encoder #(
            .CN (ch)
        ) u_enc (
            .clk_pixel    (clk_pixel),
            .reset        (reset),
            .mode         (mode),
            .video_data   (video_data[ch]),
            .control_data (control_data[ch]),
            .aux_data     (aux_data[ch]),
            .tmds         (tmds[ch])
        );
    end

endmodule

// File: rtl/tmds_terc4.sv
// -----------------------------------------------------------------------------
// tmds_terc4
// Combinational TERC4 lookup used during data islands and data guard bands.
// Ports:
//   nibble  in   4  TERC4 input nibble
//   symbol  out 10  encoded symbol, bit 0 transmitted first
// -----------------------------------------------------------------------------
module tmds_terc4
    import hdmi_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [9:0] symbol
);

    assign symbol = TERC4_TABLE[nibble];

endmodule

// File: rtl/tmds_channel_encoder.sv
// -----------------------------------------------------------------------------
// tmds_channel_encoder
// One TMDS/TERC4 channel encoder, two register stages deep.
// Stage 1 registers the symbol type and side data together with the
// transition-minimised word q_m; stage 2 applies DC balancing (video) or
// selects a fixed/TERC4 symbol and registers the result onto tmds.
// Parameter:
//   CN            channel number 0..2, selects the guard-band code set
// Ports:
//   clk_pixel     in   1  pixel clock
//   reset         in   1  synchronous, active-high
//   mode          in   3  symbol type (see hdmi_pkg::tmds_mode_e, 5..7 = CONTROL)
//   video_data    in   8  pixel component for VIDEO
//   control_data  in   2  {c1,c0} for CONTROL
//   aux_data      in   4  TERC4 nibble for DATA_ISLAND / DATA_GUARD on CN0
//   tmds          out 10  registered symbol, bit 0 transmitted first
// -----------------------------------------------------------------------------
module tmds_channel_encoder
    import hdmi_pkg::*;
#(
    parameter int CN = 0
)
(
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic [2:0] mode,
    input  logic [7:0] video_data,
    input  logic [1:0] control_data,
    input  logic [3:0] aux_data,
    output logic [9:0] tmds
);

    function automatic logic [3:0] ones8(input logic [7:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, d[i]};
        end
        return n;
    endfunction

    // Transition minimisation: XNOR chaining when the byte is ones-heavy
    // (ties broken by d[0]), q_m[8] records which chain was used.
    function automatic logic [8:0] encode_qm(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] q;
        n1       = ones8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    // ---- stage 1: register symbol type, side data and q_m ----
    tmds_mode_e mode_p1;
    logic [1:0] ctrl_p1;
    logic [3:0] aux_p1;
    logic [8:0] qm_p1;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            mode_p1 <= MODE_CONTROL;
            ctrl_p1 <= 2'b00;
            aux_p1  <= 4'h0;
            qm_p1   <= 9'h000;
        end else begin
            mode_p1 <= decode_mode(mode);
            ctrl_p1 <= control_data;
            aux_p1  <= aux_data;
            qm_p1   <= encode_qm(video_data);
        end
    end

    // ---- stage 2: DC balance / symbol select, register tmds and cnt ----
    logic signed [4:0] cnt_p2;
    logic        [9:0] terc4_sym;
    logic        [3:0] qm_ones;
    logic signed [5:0] bal;       // N1 - N0 of q_m[7:0], range -8..+8
    logic signed [5:0] cnt_ext;
    logic signed [5:0] cnt_sum;
    logic        [9:0] video_sym;
    logic        [9:0] sym_nxt;
    logic signed [4:0] cnt_nxt;
    logic              qm8;
    logic        [7:0] qm;

    tmds_terc4 u_terc4 (
        .nibble (aux_p1),
        .symbol (terc4_sym)
    );

    assign qm      = qm_p1[7:0];
    assign qm8     = qm_p1[8];
    assign qm_ones = ones8(qm);
    assign bal     = $signed({1'b0, qm_ones, 1'b0}) - 6'sd8;
    assign cnt_ext = {cnt_p2[4], cnt_p2};

    // Six-bit intermediate keeps the sum exact; the running disparity itself
    // is bounded to -10..+10 and fits the five-bit register.
    always_comb begin
        video_sym = '0;
        cnt_sum   = cnt_ext;
        if ((cnt_p2 == 5'sd0) || (bal == 6'sd0)) begin
            video_sym = {~qm8, qm8, (qm8 ? qm : ~qm)};
            cnt_sum   = qm8 ? (cnt_ext + bal) : (cnt_ext - bal);
        end else if (((cnt_p2 > 5'sd0) && (bal > 6'sd0)) ||
                     ((cnt_p2 < 5'sd0) && (bal < 6'sd0))) begin
            video_sym = {1'b1, qm8, ~qm};
            cnt_sum   = cnt_ext + (qm8 ? 6'sd2 : 6'sd0) - bal;
        end else begin
            video_sym = {1'b0, qm8, qm};
            cnt_sum   = cnt_ext - (qm8 ? 6'sd0 : 6'sd2) + bal;
        end
    end

    // Every non-video symbol clears the disparity so the next video period
    // starts balanced.
    always_comb begin
        sym_nxt = control_code(ctrl_p1);
        cnt_nxt = 5'sd0;
        case (mode_p1)
            MODE_VIDEO: begin
                sym_nxt = video_sym;
                cnt_nxt = cnt_sum[4:0];
            end
            MODE_DATA_ISLAND: sym_nxt = terc4_sym;
            MODE_VIDEO_GUARD: sym_nxt = (CN == 1) ? GUARD_CODE_B : GUARD_CODE_A;
            MODE_DATA_GUARD:  sym_nxt = (CN == 0) ? terc4_sym : GUARD_CODE_B;
            default:          sym_nxt = control_code(ctrl_p1);
        endcase
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            tmds   <= CTRL_CODE_00;
            cnt_p2 <= 5'sd0;
        end else begin
            tmds   <= sym_nxt;
            cnt_p2 <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_tmds_channel_encoder.sv
module tb_tmds_channel_encoder;

    logic            clk = 1'b0;
    logic            reset;
    logic [2:0]      mode;
    logic [7:0]      video_data;
    logic [1:0]      control_data;
    logic [3:0]      aux_data;
    logic [9:0]      tmds0;
    logic [2:0][9:0] w_tmds;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int mcnt [3];

    typedef struct {
        logic [9:0] e0;
        logic [9:0] e1;
        logic [9:0] e2;
        int         ecnt;
        int         due;
    } sb_t;
    sb_t sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tmds_channel_encoder #(.CN(0)) dut (
        .clk_pixel    (clk),
        .reset        (reset),
        .mode         (mode),
        .video_data   (video_data),
        .control_data (control_data),
        .aux_data     (aux_data),
        .tmds         (tmds0)
    );

    tmds_encoder_3ch u_3ch (
        .clk_pixel    (clk),
        .reset        (reset),
        .mode         (mode),
        .video_data   ({3{video_data}}),
        .control_data ({3{control_data}}),
        .aux_data     ({3{aux_data}}),
        .tmds         (w_tmds)
    );

    function automatic logic [9:0] ref_terc4(input logic [3:0] a);
        case (a)
            4'h0: return 10'b1010011100;  4'h1: return 10'b1001100011;
            4'h2: return 10'b1011100100;  4'h3: return 10'b1011100010;
            4'h4: return 10'b0101110001;  4'h5: return 10'b0100011110;
            4'h6: return 10'b0110001110;  4'h7: return 10'b0100111100;
            4'h8: return 10'b1011001100;  4'h9: return 10'b0100111001;
            4'hA: return 10'b0110011100;  4'hB: return 10'b1011000110;
            4'hC: return 10'b1010001110;  4'hD: return 10'b1001110001;
            4'hE: return 10'b0101100011;  default: return 10'b1011000011;
        endcase
    endfunction

    // Reference model of one channel; updates mcnt[cn].
    task automatic model_step(input int cn, input logic [2:0] m, input logic [7:0] d,
                              input logic [1:0] c, input logic [3:0] a, output logic [9:0] sym);
        int n1, nq1, nq0, k;
        logic xn, q8;
        logic [7:0] q;
        if (m == 3'd1) begin
            n1 = $countones(d);
            xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
            q = 8'h00;
            q[0] = d[0];
            for (int i = 1; i < 8; i++) q[i] = xn ? (q[i-1] ~^ d[i]) : (q[i-1] ^ d[i]);
            q8 = ~xn;
            nq1 = $countones(q);
            nq0 = 8 - nq1;
            k = mcnt[cn];
            if (k == 0 || nq1 == nq0) begin
                sym = {~q8, q8, (q8 ? q : ~q)};
                k = k + (q8 ? (nq1 - nq0) : (nq0 - nq1));
            end else if ((k > 0 && nq1 > nq0) || (k < 0 && nq0 > nq1)) begin
                sym = {1'b1, q8, ~q};
                k = k + (q8 ? 2 : 0) + nq0 - nq1;
            end else begin
                sym = {1'b0, q8, q};
                k = k + (q8 ? 0 : -2) + nq1 - nq0;
            end
            mcnt[cn] = k;
        end else begin
            mcnt[cn] = 0;
            case (m)
                3'd2: sym = ref_terc4(a);
                3'd3: sym = (cn == 1) ? 10'b0100110011 : 10'b1011001100;
                3'd4: sym = (cn == 0) ? ref_terc4(a) : 10'b0100110011;
                default: begin
                    case (c)
                        2'd0: sym = 10'b1101010100;
                        2'd1: sym = 10'b0010101011;
                        2'd2: sym = 10'b0101010100;
                        default: sym = 10'b1010101011;
                    endcase
                end
            endcase
        end
    endtask

    // Drive one input symbol and queue its expected output two edges later.
    task automatic drive(input logic [2:0] m, input logic [7:0] d, input logic [1:0] c, input logic [3:0] a);
        sb_t it;
        logic [9:0] s0, s1, s2;
        mode = m; video_data = d; control_data = c; aux_data = a;
        model_step(0, m, d, c, a, s0);
        model_step(1, m, d, c, a, s1);
        model_step(2, m, d, c, a, s2);
        it.e0 = s0; it.e1 = s1; it.e2 = s2;
        it.ecnt = mcnt[0];
        it.due = cyc + 2;
        sb.push_back(it);
    endtask

    // CONTROL/00 filler that is not scoreboarded; it clears the disparity.
    task automatic idle();
        mode = 3'd0; video_data = 8'h00; control_data = 2'b00; aux_data = 4'h0;
        for (int i = 0; i < 3; i++) mcnt[i] = 0;
    endtask

    task automatic test_reset();
        sb_t it;
        reset = 1'b1;
        idle();
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (tmds0 !== 10'b1101010100) begin n_bad++; $display("FAIL reset_ch0 cyc %0d: got %b want 1101010100", cyc, tmds0); end
            n_cmp++; if (w_tmds[1] !== 10'b1101010100) begin n_bad++; $display("FAIL reset_ch1 cyc %0d: got %b want 1101010100", cyc, w_tmds[1]); end
            n_cmp++; if (w_tmds[2] !== 10'b1101010100) begin n_bad++; $display("FAIL reset_ch2 cyc %0d: got %b want 1101010100", cyc, w_tmds[2]); end
        end
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            n_cmp++; if (tmds0 !== 10'b1101010100) begin n_bad++; $display("FAIL post_reset_hold cyc %0d: got %b want 1101010100", cyc, tmds0); end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                it = sb.pop_front();
                n_cmp++; if (tmds0 !== it.e0) begin n_bad++; $display("FAIL reset_ctrl ch0 cyc %0d: got %b want %b", cyc, tmds0, it.e0); end
                n_cmp++; if (dut.cnt_p2 !== 5'(it.ecnt)) begin n_bad++; $display("FAIL reset_ctrl cnt cyc %0d: got %0d want %0d", cyc, $signed(dut.cnt_p2), it.ecnt); end
            end
            if (i < 5) drive(3'd0, 8'h00, 2'b00, 4'h0); else idle();
        end
    endtask

    task automatic test_video_zero();
        sb_t it;
        logic [9:0] lit [3];
        int litc [3];
        int j = 0;
        lit[0] = 10'h100; lit[1] = 10'h3FF; lit[2] = 10'h100;
        litc[0] = -8; litc[1] = 2; litc[2] = -6;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                it = sb.pop_front();
                n_cmp++; if (tmds0 !== it.e0) begin n_bad++; $display("FAIL video_zero model cyc %0d: got %h want %h", cyc, tmds0, it.e0); end
                n_cmp++; if (tmds0 !== lit[j]) begin n_bad++; $display("FAIL video_zero sym%0d: got %h want %h", j, tmds0, lit[j]); end
                n_cmp++; if (dut.cnt_p2 !== 5'(litc[j])) begin n_bad++; $display("FAIL video_zero cnt%0d: got %0d want %0d", j, $signed(dut.cnt_p2), litc[j]); end
                n_cmp++; if (w_tmds[1] !== lit[j]) begin n_bad++; $display("FAIL video_zero ch1 sym%0d: got %h want %h", j, w_tmds[1], lit[j]); end
                j++;
            end
            if (i < 3) drive(3'd1, 8'h00, 2'b00, 4'h0); else idle();
        end
    endtask

    task automatic test_control_then_video();
        sb_t it;
        logic [9:0] lit [3];
        logic [2:0] md [3];
        logic [1:0] cd [3];
        int j = 0;
        md[0] = 3'd1; md[1] = 3'd0; md[2] = 3'd1;
        cd[0] = 2'b00; cd[1] = 2'b01; cd[2] = 2'b00;
        lit[0] = 10'h100; lit[1] = 10'b0010101011; lit[2] = 10'h100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                it = sb.pop_front();
                n_cmp++; if (tmds0 !== it.e0) begin n_bad++; $display("FAIL ctrl_video model cyc %0d: got %h want %h", cyc, tmds0, it.e0); end
                n_cmp++; if (tmds0 !== lit[j]) begin n_bad++; $display("FAIL ctrl_video sym%0d: got %b want %b", j, tmds0, lit[j]); end
                j++;
            end
            if (i < 3) drive(md[i], 8'h00, cd[i], 4'h0); else idle();
        end
    endtask

    task automatic test_guard_codes();
        sb_t it;
        logic [2:0] md [8];
        logic [1:0] cd [8];
        logic [3:0] ad [8];
        logic [9:0] l0 [8];
        logic [9:0] l1 [8];
        logic [9:0] l2 [8];
        int j = 0;
        md = '{3'd3, 3'd4, 3'd2, 3'd2, 3'd0, 3'd0, 3'd5, 3'd7};
        cd = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd3, 2'd1, 2'd3};
        ad = '{4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
        l0 = '{10'h2CC, 10'h29C, 10'h29C, 10'h2CC, 10'h154, 10'h2AB, 10'h0AB, 10'h2AB};
        l1 = '{10'h133, 10'h133, 10'h29C, 10'h2CC, 10'h154, 10'h2AB, 10'h0AB, 10'h2AB};
        l2 = '{10'h2CC, 10'h133, 10'h29C, 10'h2CC, 10'h154, 10'h2AB, 10'h0AB, 10'h2AB};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                it = sb.pop_front();
                n_cmp++; if (tmds0 !== l0[j]) begin n_bad++; $display("FAIL codes ch0 sym%0d: got %b want %b", j, tmds0, l0[j]); end
                n_cmp++; if (w_tmds[1] !== l1[j]) begin n_bad++; $display("FAIL codes ch1 sym%0d: got %b want %b", j, w_tmds[1], l1[j]); end
                n_cmp++; if (w_tmds[2] !== l2[j]) begin n_bad++; $display("FAIL codes ch2 sym%0d: got %b want %b", j, w_tmds[2], l2[j]); end
                n_cmp++; if (w_tmds[2] !== it.e2) begin n_bad++; $display("FAIL codes ch2 model sym%0d: got %b want %b", j, w_tmds[2], it.e2); end
                j++;
            end
            if (i < 8) drive(md[i], 8'h00, cd[i], ad[i]); else idle();
        end
    endtask

    task automatic test_random_stream(input string nm, input int n, input bit video_only);
        sb_t it;
        logic [2:0] m;
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                it = sb.pop_front();
                n_cmp++; if (tmds0 !== it.e0) begin n_bad++; $display("FAIL %s ch0 cyc %0d: got %h want %h", nm, cyc, tmds0, it.e0); end
                n_cmp++; if (w_tmds[1] !== it.e1) begin n_bad++; $display("FAIL %s ch1 cyc %0d: got %h want %h", nm, cyc, w_tmds[1], it.e1); end
                n_cmp++; if (w_tmds[2] !== it.e2) begin n_bad++; $display("FAIL %s ch2 cyc %0d: got %h want %h", nm, cyc, w_tmds[2], it.e2); end
                n_cmp++; if (dut.cnt_p2 !== 5'(it.ecnt)) begin n_bad++; $display("FAIL %s cnt cyc %0d: got %0d want %0d", nm, cyc, $signed(dut.cnt_p2), it.ecnt); end
                n_cmp++; if ($signed(dut.cnt_p2) > 10 || $signed(dut.cnt_p2) < -10) begin n_bad++; $display("FAIL %s cnt_range cyc %0d: got %0d want -10..10", nm, cyc, $signed(dut.cnt_p2)); end
            end
            if (i < n) begin
                m = (video_only || $urandom_range(0, 1) == 1) ? 3'd1 : 3'($urandom_range(0, 7));
                drive(m, 8'($urandom), 2'($urandom), 4'($urandom));
            end else begin
                idle();
            end
        end
    endtask

    task automatic test_midstream_reset();
        sb_t it;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                it = sb.pop_front();
                n_cmp++; if (tmds0 !== it.e0) begin n_bad++; $display("FAIL midreset pre ch0 cyc %0d: got %h want %h", cyc, tmds0, it.e0); end
            end
            drive(3'd1, 8'($urandom), 2'b00, 4'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        for (int i = 0; i < 3; i++) mcnt[i] = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++; if (tmds0 !== 10'b1101010100) begin n_bad++; $display("FAIL midreset ch0 cyc %0d: got %b want 1101010100", cyc, tmds0); end
            n_cmp++; if (w_tmds[1] !== 10'b1101010100) begin n_bad++; $display("FAIL midreset ch1 cyc %0d: got %b want 1101010100", cyc, w_tmds[1]); end
            n_cmp++; if (dut.cnt_p2 !== 5'sd0) begin n_bad++; $display("FAIL midreset cnt cyc %0d: got %0d want 0", cyc, $signed(dut.cnt_p2)); end
        end
        reset = 1'b0;
        drive(3'd1, 8'h00, 2'b00, 4'h0);
        @(negedge clk);
        n_cmp++; if (tmds0 !== 10'b1101010100) begin n_bad++; $display("FAIL midreset hold cyc %0d: got %b want 1101010100", cyc, tmds0); end
        idle();
        @(negedge clk);
        if (sb.size() > 0 && sb[0].due == cyc) begin
            it = sb.pop_front();
            n_cmp++; if (tmds0 !== 10'h100) begin n_bad++; $display("FAIL midreset first_video: got %h want 100", tmds0); end
            n_cmp++; if (tmds0 !== it.e0) begin n_bad++; $display("FAIL midreset model: got %h want %h", tmds0, it.e0); end
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        mode = 3'd0; video_data = 8'h00; control_data = 2'b00; aux_data = 4'h0;
        for (int i = 0; i < 3; i++) mcnt[i] = 0;
        test_reset();
        test_video_zero();
        test_control_then_video();
        test_guard_codes();
        test_random_stream("back_to_back", 400, 1'b0);
        test_random_stream("random_video", 10000, 1'b1);
        test_midstream_reset();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tmds_channel_encoder.md
TMDS_CHANNEL_ENCODER -- requirements
Module: tmds_channel_encoder

Interface
REQ-001 Parameter CN, default 0: channel number 0..2, selects the guard-band code set.
REQ-002 clk_pixel  input  1  pixel clock; the only clock in the block.
REQ-003 reset  input  1  reset; synchronous, active-high.
REQ-004 mode  input  3  symbol type: 0 CONTROL, 1 VIDEO, 2 DATA_ISLAND, 3 VIDEO_GUARD, 4 DATA_GUARD; values 5..7 SHALL be treated as CONTROL.
REQ-005 video_data  input  8  pixel component, used when mode=VIDEO.
REQ-006 control_data  input  2  {c1,c0}, used when mode=CONTROL.
REQ-007 aux_data  input  4  TERC4 nibble, used when mode=DATA_ISLAND, and on CN0 when mode=DATA_GUARD.
REQ-008 tmds  output  10  registered symbol; bit 0 is transmitted first; feeds the 10:1 serializer directly.

Function
REQ-009 Latency SHALL be exactly 2 clk_pixel cycles from input sample to tmds, for every mode, with no bubbles.
REQ-010 Stage 1 SHALL register mode, control_data and aux_data, plus q_m[8:0] computed from video_data.
REQ-011 q_m rule: n1 = ones(video_data); if n1>4, or n1==4 with d[0]==0, use XNOR chaining and set q_m[8]=0; otherwise use XOR chaining and set q_m[8]=1; q_m[0]=d[0].
REQ-012 Stage 2 SHALL hold signed 5-bit running disparity cnt; N1/N0 are the ones/zeros counts of q_m[7:0].
REQ-013 Case A, cnt==0 or N1==N0:
- tmds = {~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}
- cnt += q_m8 ? N1-N0 : N0-N1
REQ-014 Case B, (cnt>0 and N1>N0) or (cnt<0 and N0>N1):
- tmds = {1, q_m8, ~q_m[7:0]}
- cnt += 2*q_m8 + N0-N1
REQ-015 Case C, otherwise:
- tmds = {0, q_m8, q_m[7:0]}
- cnt += -2*(~q_m8) + N1-N0
REQ-016 Arithmetic SHALL be signed; cnt stays within -10..+10 and never wraps.
REQ-017 CONTROL SHALL emit (tmds[9:0]):
- 00 -> 1101010100
- 01 -> 0010101011
- 10 -> 0101010100
- 11 -> 1010101011
REQ-018 DATA_ISLAND SHALL emit the HDMI 1.4b TERC4 code for aux_data.
REQ-019 VIDEO_GUARD SHALL emit 1011001100 for CN0 and CN2, and 0100110011 for CN1.
REQ-020 DATA_GUARD SHALL emit TERC4(aux_data) for CN0, and 0100110011 for CN1 and CN2.
REQ-021 In every non-VIDEO mode, cnt SHALL be loaded with 0 in the cycle that mode reaches stage 2.
REQ-022 VIDEO after any non-VIDEO symbol SHALL start from cnt=0.
REQ-023 Mode changes on consecutive cycles SHALL each take effect exactly 2 cycles later, with no interaction between them.

Reset
REQ-024 While reset=1 at a clk_pixel edge, all stage registers SHALL load CONTROL with control_data=00, and cnt SHALL load 0.
REQ-025 tmds SHALL read 1101010100 from the first edge with reset=1.
REQ-026 After reset deasserts, tmds SHALL hold 1101010100 until the first sampled input reaches stage 2.
REQ-027 Reset asserted mid-stream SHALL discard both pipeline stages; there is no partial output.

Structure
REQ-028 Shared package hdmi_pkg SHALL hold:
- the mode enum (3-bit)
- the four control-code constants
- the two guard-band constants
- the 16-entry TERC4 table
REQ-029 One combinational sub-module, tmds_terc4 (4-bit in, 10-bit out), SHALL implement the TERC4 lookup.
REQ-030 A 3-channel wrapper SHALL instantiate three tmds_channel_encoder with CN=0,1,2, driving the serializer's three symbol inputs.

Verification
REQ-031 Reset: assert reset 3 cycles, then hold CONTROL/00 -> tmds=1101010100 on every cycle.
REQ-032 VIDEO 0x00 on three consecutive cycles from cnt=0 -> tmds 0x100, 0x3FF, 0x100; cnt -8, +2, -6.
REQ-033 CONTROL 01, then VIDEO 0x00 -> 0010101011, then 0x100, proving the cnt reset by a non-VIDEO symbol.
REQ-034 CN1: VIDEO_GUARD, then DATA_GUARD with aux_data=0 -> 0100110011, 0100110011.
REQ-035 CN0: DATA_ISLAND with aux_data=0 and 8 -> 1010011100 and 1011001100.
REQ-036 Random VIDEO for 10k cycles checked against a reference model -> bit-exact output, |cnt|<=10, every output exactly 2 cycles after its input.
